// File: rtl/ysyx_25040105_pkg.sv
// ysyx_25040105_pkg: shared IFU constants, FSM state and PC-select encodings
package ysyx_25040105_pkg;
  localparam logic [31:0] RESET_PC = 32'h8000_0000;
  localparam logic [31:0] PC_INC   = 32'd4;
  typedef enum logic [2:0] {IDLE, REQ, WAIT, FULL, HALT} ifu_state_e;
  typedef enum logic [1:0] {PC_HOLD, PC_INC4, PC_REDIR} pc_sel_e;
endpackage

// File: rtl/ysyx_25040105_pc_reg.sv
// ysyx_25040105_pc_reg: fetch PC register with hold/+4/redirect select and target alignment handling
// YSYX_25040105_IFU_ALIGN_CHK_EN keeps misaligned targets and flags them; otherwise bits [1:0] are cleared
module ysyx_25040105_pc_reg
  import ysyx_25040105_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  i_sel,
  input  logic [31:0] i_redirect_pc,
  output logic [31:0] o_pc,
  output logic        o_mis
);
  logic [31:0] r_pc;
  logic [31:0] w_tgt;
`ifdef YSYX_25040105_IFU_ALIGN_CHK_EN
  assign w_tgt = i_redirect_pc;
  assign o_mis = (i_sel == PC_REDIR) && (i_redirect_pc[1:0] != 2'b00);
`else
  assign w_tgt = i_redirect_pc & ~32'd3;
  assign o_mis = 1'b0;
`endif
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_pc <= RESET_PC;
    else if (i_sel == PC_REDIR) r_pc <= w_tgt;
    else if (i_sel == PC_INC4) r_pc <= r_pc + PC_INC;
  end
  assign o_pc = r_pc;
endmodule

// File: rtl/ysyx_25040105_ifu.sv
// ysyx_25040105_ifu: single-outstanding instruction fetch with one-entry output buffer and redirect/kill
// YSYX_25040105_IFU_ALIGN_CHK_EN enables misaligned-redirect fault delivery and the HALT state
module ysyx_25040105_ifu
  import ysyx_25040105_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_inst,
  output logic [31:0] out_pc,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        fetch_fault
);
  ifu_state_e  r_state, w_nxt;
  pc_sel_e     w_sel;
  logic        r_kill, r_fault, w_hs, w_mis, w_load, w_set_kill;
  logic [31:0] r_inst, w_pc;

  ysyx_25040105_pc_reg u_pc (
    .clk          (clk),
    .rst          (rst),
    .i_sel        (w_sel),
    .i_redirect_pc(redirect_pc),
    .o_pc         (w_pc),
    .o_mis        (w_mis)
  );

  assign w_sel = redirect_valid ? PC_REDIR
               : (r_state == FULL && out_ready && !r_fault) ? PC_INC4 : PC_HOLD;
  assign w_hs = imem_req_valid && imem_req_ready;
  assign w_load = r_state == WAIT && imem_resp_valid && !r_kill && !redirect_valid;
  // a response that is accepted but no longer wanted must be swallowed when it arrives
  assign w_set_kill = redirect_valid
                   && ((r_state == REQ && w_hs) || (r_state == WAIT && !imem_resp_valid));

  always_comb begin
    w_nxt = r_state;
    if (redirect_valid)
      w_nxt = w_mis ? FULL
            : ((r_state == REQ && w_hs) || (r_state == WAIT && !imem_resp_valid)) ? WAIT : REQ;
    else if (r_state == IDLE) w_nxt = REQ;
    else if (r_state == REQ) w_nxt = w_hs ? WAIT : REQ;
    else if (r_state == WAIT) w_nxt = imem_resp_valid ? (r_kill ? REQ : FULL) : WAIT;
    else if (r_state == FULL && out_ready) w_nxt = r_fault ? HALT : REQ;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_kill  <= 1'b0;
      r_fault <= 1'b0;
      r_inst  <= '0;
    end else begin
      r_state <= w_nxt;
      r_kill  <= w_set_kill || (r_kill && !imem_resp_valid);
      if (w_mis) begin
        r_inst  <= '0;
        r_fault <= 1'b1;
      end else if (w_load) begin
        r_inst  <= imem_resp_data;
        r_fault <= 1'b0;
      end
    end
  end

  assign imem_req_valid = r_state == REQ && !r_kill;
  assign imem_req_addr  = w_pc;
  assign out_valid      = r_state == FULL;
  assign out_inst       = r_inst;
  assign out_pc         = w_pc;
`ifdef YSYX_25040105_IFU_ALIGN_CHK_EN
  assign fetch_fault = r_state == FULL && r_fault;
`else
  assign fetch_fault = 1'b0;
`endif
endmodule
